// File: rtl/systolic_data_deskew_unit.sv
// Return-path deskew: delays column i by (MATRIX_WIDTH-1-i) enabled cycles so a
// diagonally emitted result row leaves as one aligned word vector with its tag.
module systolic_data_deskew_unit #(
  parameter int MATRIX_WIDTH = 14,
  parameter int DATA_WIDTH   = 32,
  parameter int TAG_WIDTH    = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               enable,
  input  logic                               valid_in,
  input  logic [TAG_WIDTH-1:0]               tag_in,
  input  logic [MATRIX_WIDTH*DATA_WIDTH-1:0] data_in,
  output logic [MATRIX_WIDTH*DATA_WIDTH-1:0] data_out,
  output logic [TAG_WIDTH-1:0]               tag_out,
  output logic                               valid_out,
  output logic                               busy
);

  localparam int VEC_WIDTH = MATRIX_WIDTH * DATA_WIDTH;

  logic [VEC_WIDTH-1:0] chain_data;
  logic                 chain_valid;
  logic [TAG_WIDTH-1:0] chain_tag;

  // Column i arrives i cycles late, so it needs the complementary delay.
  for (genvar i = 0; i < MATRIX_WIDTH; i++) begin : g_col
    localparam int DEPTH = MATRIX_WIDTH - 1 - i;
    if (DEPTH == 0) begin : g_direct
      assign chain_data[i*DATA_WIDTH +: DATA_WIDTH] = data_in[i*DATA_WIDTH +: DATA_WIDTH];
    end else begin : g_delay
      logic [DATA_WIDTH-1:0] stage [DEPTH];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 0; k < DEPTH; k++) stage[k] <= '0;
        end else if (enable) begin
          stage[0] <= data_in[i*DATA_WIDTH +: DATA_WIDTH];
          for (int k = 1; k < DEPTH; k++) stage[k] <= stage[k-1];
        end
      end

      assign chain_data[i*DATA_WIDTH +: DATA_WIDTH] = stage[DEPTH-1];
    end
  end

  // Valid/tag ride alongside column 0, which has the longest delay.
  if (MATRIX_WIDTH == 1) begin : g_side_direct
    assign chain_valid = valid_in;
    assign chain_tag   = tag_in;
    assign busy        = 1'b0;
  end else begin : g_side_delay
    localparam int STAGES = MATRIX_WIDTH - 1;
    logic [STAGES-1:0]    valid_sr;
    logic [TAG_WIDTH-1:0] tag_sr [STAGES];

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_sr <= '0;
        for (int k = 0; k < STAGES; k++) tag_sr[k] <= '0;
      end else if (enable) begin
        valid_sr[0] <= valid_in;
        tag_sr[0]   <= tag_in;
        for (int k = 1; k < STAGES; k++) begin
          valid_sr[k] <= valid_sr[k-1];
          tag_sr[k]   <= tag_sr[k-1];
        end
      end
    end

    assign chain_valid = valid_sr[STAGES-1];
    assign chain_tag   = tag_sr[STAGES-1];
    assign busy        = |valid_sr;
  end

  // A stalled edge drops the strobe so each row is reported only once.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out  <= '0;
      tag_out   <= '0;
      valid_out <= 1'b0;
    end else if (enable) begin
      data_out  <= chain_data;
      tag_out   <= chain_tag;
      valid_out <= chain_valid;
    end else begin
      valid_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_systolic_data_deskew_unit.sv
// Bench for the deskew unit: a MATRIX_WIDTH=4 instance checked against a row-level
// model, plus a MATRIX_WIDTH=1 instance checked as a single output register.
module tb_systolic_data_deskew_unit;

  localparam int MW   = 4;
  localparam int DW   = 32;
  localparam int TW   = 16;
  localparam int MAXR = 4096;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          valid_in;
  logic [TW-1:0] tag_in;
  logic [MW*DW-1:0] data_in;
  logic [MW*DW-1:0] data_out;
  logic [TW-1:0] tag_out;
  logic          valid_out;
  logic          busy;

  logic          valid_in1;
  logic [TW-1:0] tag_in1;
  logic [DW-1:0] data_in1;
  logic [DW-1:0] data_out1;
  logic [TW-1:0] tag_out1;
  logic          valid_out1;
  logic          busy1;

  systolic_data_deskew_unit #(.MATRIX_WIDTH(MW), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) dut (
    .clk(clk), .rst(rst), .enable(enable), .valid_in(valid_in), .tag_in(tag_in),
    .data_in(data_in), .data_out(data_out), .tag_out(tag_out),
    .valid_out(valid_out), .busy(busy)
  );

  systolic_data_deskew_unit #(.MATRIX_WIDTH(1), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) dut1 (
    .clk(clk), .rst(rst), .enable(enable), .valid_in(valid_in1), .tag_in(tag_in1),
    .data_in(data_in1), .data_out(data_out1), .tag_out(tag_out1),
    .valid_out(valid_out1), .busy(busy1)
  );

  always #5 clk = ~clk;

  int num_checks = 0;
  int num_fail   = 0;

  // Row store indexed by the enabled edge at which column 0 was sampled.
  bit            row_valid [MAXR];
  logic [TW-1:0] row_tag   [MAXR];
  logic [DW-1:0] row_data  [MAXR][MW];
  int            edge_idx   = 0;
  int            reset_base = 0;

  logic             exp_known;
  logic [MW*DW-1:0] exp_data;
  logic [TW-1:0]    exp_tag;
  logic             exp_busy;
  logic [DW-1:0]    exp1_data;
  logic [TW-1:0]    exp1_tag;

  task automatic checkOutput(input string name, input logic [MW*DW-1:0] actual,
                             input logic [MW*DW-1:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic bit row_live(input int idx);
    return idx >= 0 && idx >= reset_base && row_valid[idx];
  endfunction

  // One clock of stimulus followed by model update and output checks.
  task automatic applyStimulus(input logic en, input logic rs, input logic issue,
                               input logic [TW-1:0] tg, input logic [DW-1:0] base,
                               input logic rand_data);
    int idx;
    int src;
    logic v;
    logic [DW-1:0] d1v;
    if (issue && en && !rs) begin
      row_valid[edge_idx] = 1'b1;
      row_tag[edge_idx]   = tg;
      for (int i = 0; i < MW; i++)
        row_data[edge_idx][i] = rand_data ? $urandom : base + DW'(i);
    end
    valid_in = issue;
    tag_in   = tg;
    for (int i = 0; i < MW; i++) begin
      idx = edge_idx - i;
      data_in[i*DW +: DW] = (idx >= 0 && row_valid[idx]) ? row_data[idx][i] : $urandom;
    end
    d1v       = rand_data ? $urandom : base;
    valid_in1 = issue;
    tag_in1   = tg;
    data_in1  = d1v;
    enable    = en;
    rst       = rs;
    @(posedge clk);
    #1;
    if (rs) begin
      reset_base = edge_idx;
      exp_known  = 1'b1;
      exp_data   = '0;
      exp_tag    = '0;
      exp_busy   = 1'b0;
      checkOutput("rst_valid", {127'b0, valid_out}, '0);
      exp1_data  = '0;
      exp1_tag   = '0;
      checkOutput("rst_valid1", {127'b0, valid_out1}, '0);
    end else if (en) begin
      src = edge_idx - (MW - 1);
      v   = row_live(src);
      checkOutput("valid", {127'b0, valid_out}, {127'b0, v});
      exp_known = v;
      if (v) begin
        exp_tag = row_tag[src];
        for (int i = 0; i < MW; i++) exp_data[i*DW +: DW] = row_data[src][i];
      end
      exp_busy = 1'b0;
      for (int k = 0; k < MW - 1; k++)
        if (row_live(edge_idx - k)) exp_busy = 1'b1;
      edge_idx++;
      checkOutput("valid1", {127'b0, valid_out1}, {127'b0, issue});
      exp1_data = d1v;
      exp1_tag  = tg;
    end else begin
      checkOutput("stall_valid", {127'b0, valid_out}, '0);
      checkOutput("stall_valid1", {127'b0, valid_out1}, '0);
    end
    if (exp_known) begin
      checkOutput("data", data_out, exp_data);
      checkOutput("tag", {112'b0, tag_out}, {112'b0, exp_tag});
    end
    checkOutput("busy", {127'b0, busy}, {127'b0, exp_busy});
    checkOutput("data1", {96'b0, data_out1}, {96'b0, exp1_data});
    checkOutput("tag1", {112'b0, tag_out1}, {112'b0, exp1_tag});
    checkOutput("busy1", {127'b0, busy1}, '0);
  endtask

  task automatic idle(input int n, input logic en);
    for (int c = 0; c < n; c++) applyStimulus(en, 1'b0, 1'b0, TW'($urandom), '0, 1'b1);
  endtask

  initial begin
    exp_known = 1'b0;
    exp_busy  = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, '0, '0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, '0, '0, 1'b1);

    // single row
    applyStimulus(1'b1, 1'b0, 1'b1, 16'd5, 32'h100, 1'b0);
    idle(6, 1'b1);

    // back-to-back rows
    for (int r = 0; r < 4; r++)
      applyStimulus(1'b1, 1'b0, 1'b1, TW'(r + 1), 32'hA0 + 32'(r * 16), 1'b0);
    idle(6, 1'b1);

    // stall while the row is in flight
    applyStimulus(1'b1, 1'b0, 1'b1, 16'd5, 32'h100, 1'b0);
    idle(1, 1'b1);
    idle(2, 1'b0);
    idle(6, 1'b1);

    // stall while the row sits on the outputs
    applyStimulus(1'b1, 1'b0, 1'b1, 16'd9, 32'h200, 1'b0);
    idle(3, 1'b1);
    idle(3, 1'b0);
    idle(2, 1'b1);

    // reset mid-flight
    applyStimulus(1'b1, 1'b0, 1'b1, 16'd3, 32'h300, 1'b0);
    idle(1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, '0, '0, 1'b1);
    idle(6, 1'b1);

    // idle garbage
    idle(20, 1'b1);

    // single-column instance directed value
    applyStimulus(1'b1, 1'b0, 1'b1, 16'd7, 32'hDEADBEEF, 1'b0);
    idle(4, 1'b1);

    // randomized traffic with stalls and occasional resets
    for (int c = 0; c < 700; c++)
      applyStimulus($urandom_range(0, 9) < 8, $urandom_range(0, 99) < 2,
                    $urandom_range(0, 1) == 1, TW'($urandom), $urandom, 1'b1);
    idle(6, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", num_checks, num_fail);
    $finish;
  end

endmodule
